// File: rtl/pulse_meter.sv
// Arms on start, then measures the low gap before the next pulse and that
// pulse's high length, and holds both behind a valid/ack handshake.
module pulse_meter #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             ack,
  input  logic             pulse_in,
  output logic             busy,
  output logic             valid,
  output logic [width-1:0] dly,
  output logic [width-1:0] len,
  output logic             tmo,
  output logic             ovf
);

  localparam logic [width-1:0] MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LO,
    WAIT_HI,
    MEAS_HI,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [width-1:0] dly_cnt_q, dly_cnt_d;
  logic [width-1:0] len_cnt_q, len_cnt_d;
  logic [width-1:0] dly_q, dly_d;
  logic [width-1:0] len_q, len_d;
  logic             tmo_q, tmo_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      dly_cnt_q <= '0;
      len_cnt_q <= '0;
      dly_q     <= '0;
      len_q     <= '0;
      tmo_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_cnt_q <= dly_cnt_d;
      len_cnt_q <= len_cnt_d;
      dly_q     <= dly_d;
      len_q     <= len_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    len_cnt_d = len_cnt_q;
    dly_d     = dly_q;
    len_d     = len_q;
    tmo_d     = tmo_q;
    ovf_d     = ovf_q;
    if (start) begin
      // A pulse already high at arm time is skipped via WAIT_LO.
      state_d   = pulse_in ? WAIT_LO : WAIT_HI;
      dly_cnt_d = '0;
      len_cnt_d = '0;
      dly_d     = '0;
      len_d     = '0;
      tmo_d     = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        WAIT_LO: begin
          if (!pulse_in) state_d = WAIT_HI;
        end
        WAIT_HI: begin
          if (pulse_in) begin
            len_cnt_d = {{(width-1){1'b0}}, 1'b1};
            state_d   = MEAS_HI;
          end else if (dly_cnt_q == MAX) begin
            dly_d   = MAX;
            len_d   = '0;
            tmo_d   = 1'b1;
            state_d = DONE;
          end else begin
            dly_cnt_d = dly_cnt_q + 1'b1;
          end
        end
        MEAS_HI: begin
          if (!pulse_in) begin
            dly_d   = dly_cnt_q;
            len_d   = len_cnt_q;
            state_d = DONE;
          end else if (len_cnt_q == MAX) begin
            dly_d   = dly_cnt_q;
            len_d   = MAX;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            len_cnt_d = len_cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy  = (state_q == WAIT_LO) ||
                 (state_q == WAIT_HI) ||
                 (state_q == MEAS_HI);
  assign valid = (state_q == DONE);
  assign dly   = dly_q;
  assign len   = len_q;
  assign tmo   = tmo_q;
  assign ovf   = ovf_q;

endmodule
